// File: rtl/elevator_ctrl_if.sv
// rtl/elevator_ctrl_if.sv - call-button and status bundle for the elevator controller
// Ports (slave view): btn in (call buttons F1..F3); floor, gf out (floor labels);
// led1..led3 out (pending calls); moving, door_open, dir_up out (car status).
interface elevator_ctrl_if;
  logic [2:0] btn;
  logic [1:0] floor;
  logic       led1;
  logic       led2;
  logic       led3;
  logic       moving;
  logic       dir_up;
  logic       door_open;
  logic [1:0] gf;

  modport master (
    output btn,
    input  floor, led1, led2, led3, moving, dir_up, door_open, gf
  );

  modport slave (
    input  btn,
    output floor, led1, led2, led3, moving, dir_up, door_open, gf
  );
endinterface

// File: rtl/elevator_ctrl.sv
// rtl/elevator_ctrl.sv - three-floor elevator controller (IDLE / MOVE / DOOR)
// Ports: clk (rising edge), rst (sync, active high), bus (elevator_ctrl_if.slave):
// btn call buttons in; floor/gf current and goal floor labels; led1..led3 pending
// calls; moving / door_open registered state decodes; dir_up travel preference.
module elevator_ctrl #(
  parameter logic [1:0]  labelF1      = 2'b00,
  parameter logic [1:0]  labelF2      = 2'b01,
  parameter logic [1:0]  labelF3      = 2'b10,
  parameter int unsigned TRAVEL_TICKS = 8,
  parameter int unsigned DOOR_TICKS   = 16
) (
  input logic             clk,
  input logic             rst,
  elevator_ctrl_if.slave  bus
);

  localparam logic [7:0] TT = 8'(TRAVEL_TICKS);
  localparam logic [7:0] DT = 8'(DOOR_TICKS);

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

  state_t     state, state_nx;
  // Floors are kept as indices 0..2 internally and mapped to labels on output.
  logic [1:0] fidx, fidx_nx;
  logic [1:0] gidx, gidx_nx;
  logic       dir, dir_nx;
  logic [2:0] req, req_nx;
  logic [7:0] tcnt, tcnt_nx;
  logic [7:0] dcnt, dcnt_nx;
  logic       moving_q, door_q;

  logic [2:0] here, step_mask, set_mask, clr_mask;
  logic [1:0] step_idx, up_idx, dn_idx;
  logic       have_up, have_dn;

  function automatic logic [1:0] to_label(input logic [1:0] i);
    case (i)
      2'd0:    to_label = labelF1;
      2'd1:    to_label = labelF2;
      default: to_label = labelF3;
    endcase
  endfunction

  // Nearest pending floor above and below the car.
  always_comb begin
    have_up = 1'b0;
    up_idx  = fidx;
    have_dn = 1'b0;
    dn_idx  = fidx;
    case (fidx)
      2'd0: begin
        if (req[1]) begin
          have_up = 1'b1;
          up_idx  = 2'd1;
        end else if (req[2]) begin
          have_up = 1'b1;
          up_idx  = 2'd2;
        end
      end
      2'd1: begin
        if (req[2]) begin
          have_up = 1'b1;
          up_idx  = 2'd2;
        end
        if (req[0]) begin
          have_dn = 1'b1;
          dn_idx  = 2'd0;
        end
      end
      default: begin
        if (req[1]) begin
          have_dn = 1'b1;
          dn_idx  = 2'd1;
        end else if (req[0]) begin
          have_dn = 1'b1;
          dn_idx  = 2'd0;
        end
      end
    endcase
  end

  // The step is clamped at the end floors; direction choice never asks for it.
  always_comb begin
    here = 3'b001 << fidx;
    if (dir) step_idx = (fidx == 2'd2) ? 2'd2 : fidx + 2'd1;
    else     step_idx = (fidx == 2'd0) ? 2'd0 : fidx - 2'd1;
    step_mask = 3'b001 << step_idx;
  end

  always_comb begin
    state_nx = state;
    fidx_nx  = fidx;
    gidx_nx  = gidx;
    dir_nx   = dir;
    tcnt_nx  = tcnt;
    dcnt_nx  = dcnt;
    set_mask = bus.btn;
    clr_mask = 3'b000;
    case (state)
      IDLE: begin
        // A call at the floor where the car stands is served at once and is
        // never latched, so its lamp does not light.
        if (((req | bus.btn) & here) != 3'b000) begin
          state_nx = DOOR;
          dcnt_nx  = DT;
          clr_mask = here;
          set_mask = bus.btn & ~here;
        end else if (req != 3'b000) begin
          state_nx = MOVE;
          tcnt_nx  = TT;
          if (dir) begin
            if (have_up) gidx_nx = up_idx;
            else begin
              gidx_nx = dn_idx;
              dir_nx  = 1'b0;
            end
          end else begin
            if (have_dn) gidx_nx = dn_idx;
            else begin
              gidx_nx = up_idx;
              dir_nx  = 1'b1;
            end
          end
        end
      end
      MOVE: begin
        if (tcnt <= 8'd1) begin
          fidx_nx = step_idx;
          tcnt_nx = TT;
          // Stop at any lit floor on the way, not only the goal.
          if ((req & step_mask) != 3'b000) begin
            state_nx = DOOR;
            dcnt_nx  = DT;
            clr_mask = step_mask;
          end
        end else begin
          tcnt_nx = tcnt - 8'd1;
        end
      end
      DOOR: begin
        // Pressing the open-door floor extends the door instead of latching.
        set_mask = bus.btn & ~here;
        if ((bus.btn & here) != 3'b000) dcnt_nx = DT;
        else if (dcnt <= 8'd1)          state_nx = IDLE;
        else                            dcnt_nx = dcnt - 8'd1;
      end
      default: state_nx = IDLE;
    endcase
    // Set wins over a coinciding clear.
    req_nx = set_mask | (req & ~clr_mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fidx     <= 2'd0;
      gidx     <= 2'd0;
      dir      <= 1'b1;
      req      <= 3'b000;
      tcnt     <= 8'd0;
      dcnt     <= 8'd0;
      moving_q <= 1'b0;
      door_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      fidx     <= fidx_nx;
      gidx     <= gidx_nx;
      dir      <= dir_nx;
      req      <= req_nx;
      tcnt     <= tcnt_nx;
      dcnt     <= dcnt_nx;
      moving_q <= (state_nx == MOVE);
      door_q   <= (state_nx == DOOR);
    end
  end

  assign bus.floor     = to_label(fidx);
  assign bus.gf        = to_label(gidx);
  assign bus.led1      = req[0];
  assign bus.led2      = req[1];
  assign bus.led3      = req[2];
  assign bus.moving    = moving_q;
  assign bus.door_open = door_q;
  assign bus.dir_up    = dir;

endmodule

// File: tb/tb_elevator_ctrl.sv
// tb/tb_elevator_ctrl.sv - self-checking bench for elevator_ctrl
module tb_elevator_ctrl;
  localparam int T = 3;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  elevator_ctrl_if bus();

  elevator_ctrl #(.TRAVEL_TICKS(T), .DOOR_TICKS(D)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] b;
    int         fl;
    logic [2:0] leds;
    logic       mv;
    logic       dr;
    int         gf;
    logic       up;
  } vec_t;

  vec_t tbl[12];

  // Reference model state: the car described in plain terms.
  int       m_mode;   // 0 waiting, 1 travelling, 2 door open
  int       m_pos;
  int       m_goal;
  bit       m_up;
  bit [2:0] m_calls;
  int       m_left;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] leds();
    return {bus.led3, bus.led2, bus.led1};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.btn = 3'b000;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_door(input string name);
    int n;
    n = 0;
    while (!bus.door_open && n < 60) begin
      tick();
      n++;
    end
    chk({name, "_door_reached"}, 32'(bus.door_open), 32'd1);
  endtask

  task automatic count_door(output int n, output logic [2:0] seen);
    n = 0;
    seen = 3'b000;
    while (bus.door_open && n < 30) begin
      n++;
      seen = seen | leds();
      tick();
    end
  endtask

  task automatic model_step(input bit [2:0] b, input bit r);
    bit [2:0] old;
    bit [2:0] nxt;
    bit       found;
    int       f;
    if (r) begin
      m_mode = 0; m_pos = 0; m_goal = 0; m_up = 1'b1; m_calls = 3'b000; m_left = 0;
      return;
    end
    old = m_calls;
    nxt = m_calls | b;
    case (m_mode)
      0: begin
        if (old[m_pos] || b[m_pos]) begin
          nxt[m_pos] = 1'b0;
          m_mode = 2;
          m_left = D;
        end else if (old != 3'b000) begin
          found = 1'b0;
          for (int pass = 0; pass < 2 && !found; pass++) begin
            for (int d = 1; d <= 2 && !found; d++) begin
              f = m_up ? m_pos + d : m_pos - d;
              if (f >= 0 && f <= 2 && old[f]) begin
                found = 1'b1;
                m_goal = f;
              end
            end
            if (!found) m_up = !m_up;
          end
          m_mode = 1;
          m_left = T;
        end
      end
      1: begin
        m_left--;
        if (m_left == 0) begin
          m_pos = m_up ? m_pos + 1 : m_pos - 1;
          m_left = T;
          if (old[m_pos]) begin
            if (!b[m_pos]) nxt[m_pos] = 1'b0;
            m_mode = 2;
            m_left = D;
          end
        end
      end
      default: begin
        nxt[m_pos] = old[m_pos];
        if (b[m_pos]) m_left = D;
        else begin
          m_left--;
          if (m_left == 0) m_mode = 0;
        end
      end
    endcase
    m_calls = nxt;
  endtask

  initial begin
    int          n;
    logic [2:0]  seen;
    int          dc;
    bit          led1_seen, moved;
    bit [2:0]    rb;
    bit          rr;
    logic [31:0] act, exp;

    // btn, floor, leds, moving, door, gf, dir_up  (F1 -> F3 call, T=3, D=4)
    tbl[0]  = '{3'b100, 0, 3'b100, 1'b0, 1'b0, 0, 1'b1};
    tbl[1]  = '{3'b000, 0, 3'b100, 1'b1, 1'b0, 2, 1'b1};
    tbl[2]  = '{3'b000, 0, 3'b100, 1'b1, 1'b0, 2, 1'b1};
    tbl[3]  = '{3'b000, 0, 3'b100, 1'b1, 1'b0, 2, 1'b1};
    tbl[4]  = '{3'b000, 1, 3'b100, 1'b1, 1'b0, 2, 1'b1};
    tbl[5]  = '{3'b000, 1, 3'b100, 1'b1, 1'b0, 2, 1'b1};
    tbl[6]  = '{3'b000, 1, 3'b100, 1'b1, 1'b0, 2, 1'b1};
    tbl[7]  = '{3'b000, 2, 3'b000, 1'b0, 1'b1, 2, 1'b1};
    tbl[8]  = '{3'b000, 2, 3'b000, 1'b0, 1'b1, 2, 1'b1};
    tbl[9]  = '{3'b000, 2, 3'b000, 1'b0, 1'b1, 2, 1'b1};
    tbl[10] = '{3'b000, 2, 3'b000, 1'b0, 1'b1, 2, 1'b1};
    tbl[11] = '{3'b000, 2, 3'b000, 1'b0, 1'b0, 2, 1'b1};

    rst = 1'b1;
    bus.btn = 3'b000;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_floor", 32'(bus.floor), 32'd0);
    chk("rst_gf", 32'(bus.gf), 32'd0);
    chk("rst_leds", 32'(leds()), 32'd0);
    chk("rst_moving", 32'(bus.moving), 32'd0);
    chk("rst_door", 32'(bus.door_open), 32'd0);
    chk("rst_dir", 32'(bus.dir_up), 32'd1);

    for (int i = 0; i < 12; i++) begin
      bus.btn = tbl[i].b;
      tick();
      chk($sformatf("vec%0d_floor", i), 32'(bus.floor), 32'(tbl[i].fl));
      chk($sformatf("vec%0d_leds", i), 32'(leds()), 32'(tbl[i].leds));
      chk($sformatf("vec%0d_moving", i), 32'(bus.moving), 32'(tbl[i].mv));
      chk($sformatf("vec%0d_door", i), 32'(bus.door_open), 32'(tbl[i].dr));
      chk($sformatf("vec%0d_gf", i), 32'(bus.gf), 32'(tbl[i].gf));
      chk($sformatf("vec%0d_dir", i), 32'(bus.dir_up), 32'(tbl[i].up));
    end

    // Call at the idle floor: door opens in place, lamp never lights.
    do_reset();
    bus.btn = 3'b001;
    tick();
    bus.btn = 3'b000;
    dc = 0; led1_seen = 1'b0; moved = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (bus.door_open) dc++;
      if (bus.led1) led1_seen = 1'b1;
      if (bus.moving) moved = 1'b1;
      tick();
    end
    chk("here_door_cycles", 32'(dc), 32'(D));
    chk("here_led1", 32'(led1_seen), 32'd0);
    chk("here_moving", 32'(moved), 32'd0);

    // Pass-through stop at F2 while heading to F3.
    do_reset();
    bus.btn = 3'b100;
    tick();
    bus.btn = 3'b000;
    tick();
    bus.btn = 3'b010;
    tick();
    bus.btn = 3'b000;
    wait_door("pass");
    chk("pass_stop_floor", 32'(bus.floor), 32'd1);
    chk("pass_leds_at_f2", 32'(leds()), 32'b100);
    count_door(n, seen);
    chk("pass_door_f2", 32'(n), 32'(D));
    wait_door("pass2");
    chk("pass_final_floor", 32'(bus.floor), 32'd2);
    count_door(n, seen);
    chk("pass_door_f3", 32'(n), 32'(D));

    // Two calls from F2 with dir_up=1: up first, then reverse.
    do_reset();
    bus.btn = 3'b010;
    tick();
    bus.btn = 3'b000;
    wait_door("dual_pre");
    count_door(n, seen);
    chk("dual_start_floor", 32'(bus.floor), 32'd1);
    chk("dual_start_dir", 32'(bus.dir_up), 32'd1);
    bus.btn = 3'b101;
    tick();
    bus.btn = 3'b000;
    tick();
    chk("dual_first_gf", 32'(bus.gf), 32'd2);
    chk("dual_first_dir", 32'(bus.dir_up), 32'd1);
    chk("dual_first_moving", 32'(bus.moving), 32'd1);
    wait_door("dual_a");
    chk("dual_first_floor", 32'(bus.floor), 32'd2);
    count_door(n, seen);
    tick();
    chk("dual_second_gf", 32'(bus.gf), 32'd0);
    chk("dual_second_dir", 32'(bus.dir_up), 32'd0);
    wait_door("dual_b");
    chk("dual_second_floor", 32'(bus.floor), 32'd0);

    // Re-press at the open-door floor on its third cycle.
    do_reset();
    bus.btn = 3'b100;
    tick();
    bus.btn = 3'b000;
    wait_door("repress");
    tick();
    tick();
    bus.btn = 3'b100;
    tick();
    bus.btn = 3'b000;
    count_door(n, seen);
    chk("repress_extra_cycles", 32'(n), 32'(D));
    chk("repress_led3", 32'(seen[2]), 32'd0);

    // Reset in the middle of a move.
    do_reset();
    bus.btn = 3'b100;
    tick();
    bus.btn = 3'b000;
    tick();
    tick();
    tick();
    chk("midrst_pre_moving", 32'(bus.moving), 32'd1);
    bus.btn = 3'b011;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.btn = 3'b000;
    chk("midrst_floor", 32'(bus.floor), 32'd0);
    chk("midrst_moving", 32'(bus.moving), 32'd0);
    chk("midrst_leds", 32'(leds()), 32'd0);
    chk("midrst_gf", 32'(bus.gf), 32'd0);
    chk("midrst_door", 32'(bus.door_open), 32'd0);

    // Random calls against the reference model.
    do_reset();
    model_step(3'b000, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      for (int j = 0; j < 3; j++) rb[j] = ($urandom_range(0, 11) == 0);
      rr = ($urandom_range(0, 299) == 0);
      bus.btn = rb;
      rst = rr;
      tick();
      model_step(rb, rr);
      act = {20'd0, bus.floor, leds(), bus.moving, bus.door_open, bus.gf, bus.dir_up};
      exp = {20'd0, 2'(m_pos), m_calls, m_mode == 1, m_mode == 2, 2'(m_goal), m_up};
      chk($sformatf("rand_cycle%0d", c), act, exp);
    end
    rst = 1'b0;
    bus.btn = 3'b000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
